// File: rtl/remote_access_bridge.sv
// remote_access_bridge
// Near-side consumer of the remote-access command/response channel. Commands
// arrive as single-cycle strobes from the UART remote decoder and are executed
// one at a time on a request/grant memory bus with byte enables. Read data goes
// back to the decoder as one single-cycle response pulse per word.
//
// Build option: define REMOTE_ACCESS_WR_ACK_EN to make every write answer with
// one response pulse carrying 32'h0000_0001 after its grant. Without the macro
// writes are silent.
//
// dbg_state exposes the FSM state (0 IDLE, 1 REQ, 2 RWAIT, 3 ACK) for checkers.

module remote_access_bridge #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_wr_word,
    input  logic        cmd_wr_halfword,
    input  logic        cmd_wr_byte,
    input  logic        cmd_rd_word,
    input  logic        cmd_rd_numwords,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err_overrun,
    output logic [1:0]  dbg_state
);

    // Handshake rules, all sampled on the rising edge of clk:
    //  - cmd_valid is a one-cycle strobe; it is accepted only in IDLE. Seen in
    //    any other state it is dropped and err_overrun latches high.
    //  - mem_req stays high with mem_we/mem_be/mem_addr/mem_wdata frozen until
    //    the cycle mem_gnt is high; that cycle is the transfer.
    //  - After a read grant exactly one mem_rvalid is expected, in any later
    //    cycle; mem_rvalid in any other state is ignored.
    //  - rsp_valid is a one-cycle strobe with no back-pressure.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RWAIT = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Captured command and running burst position
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Response and error registers
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             err_q, err_d;

    // Decoded view of the incoming command
    logic             any_cmd;
    logic             accept;
    logic             overrun;
    logic             rd_empty;
    logic             dec_we;
    logic [3:0]       dec_be;
    logic [31:0]      dec_wdata;
    logic [CNT_W-1:0] dec_cnt;

    // Command decode with fixed priority wr_word > wr_halfword > wr_byte > rd_word > rd_numwords
    always_comb begin
        any_cmd   = cmd_wr_word | cmd_wr_halfword | cmd_wr_byte
                  | cmd_rd_word | cmd_rd_numwords;
        dec_we    = 1'b0;
        dec_be    = 4'b1111;
        dec_wdata = cmd_data;
        dec_cnt   = '0;
        if (cmd_wr_word) begin
            dec_we = 1'b1;
        end else if (cmd_wr_halfword) begin
            dec_we    = 1'b1;
            dec_wdata = {2{cmd_data[15:0]}};
            dec_be    = cmd_addr[1] ? 4'b1100 : 4'b0011;
        end else if (cmd_wr_byte) begin
            dec_we    = 1'b1;
            dec_wdata = {4{cmd_data[7:0]}};
            dec_be    = 4'b0001 << cmd_addr[1:0];
        end else if (cmd_rd_word) begin
            dec_cnt = CNT_W'(1);
        end else begin
            dec_cnt = cmd_data[CNT_W-1:0];
        end
    end

    assign accept   = cmd_valid && any_cmd && (state_q == ST_IDLE);
    assign overrun  = cmd_valid && (state_q != ST_IDLE);
    // A multi-word read of zero words spends one cycle in REQ without a request
    assign rd_empty = !we_q && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_empty) begin
                    state_d = ST_IDLE;
                end else if (mem_gnt) begin
                    if (!we_q) begin
                        state_d = ST_RWAIT;
                    end else begin
`ifdef REMOTE_ACCESS_WR_ACK_EN
                        state_d = ST_ACK;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_RWAIT: begin
                if (mem_rvalid) begin
                    state_d = (cnt_q > CNT_W'(1)) ? ST_REQ : ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: bus attributes come straight from the captured command
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = we_q;
        mem_be    = be_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q;
        busy      = (state_q != ST_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        case (state_q)
            ST_REQ: begin
                mem_req = !rd_empty;
            end
            ST_ACK: begin
                rsp_valid = 1'b1;
                rsp_data  = 32'h0000_0001;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        dbg_state   = state_q;
        err_overrun = err_q;
    end

    // Datapath next values: capture on accept, advance the burst on each read beat
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        err_d       = err_q;

        if (accept) begin
            addr_d  = cmd_addr;
            wdata_d = dec_wdata;
            be_d    = dec_be;
            we_d    = dec_we;
            cnt_d   = dec_cnt;
        end

        if (overrun) begin
            err_d = 1'b1;
        end

        if ((state_q == ST_RWAIT) && mem_rvalid) begin
            rsp_data_d  = mem_rdata;
            rsp_valid_d = 1'b1;
            if (cnt_q > CNT_W'(1)) begin
                cnt_d  = cnt_q - CNT_W'(1);
                // 32-bit wrap is intended: 0xFFFFFFFC is followed by 0x00000000
                addr_d = addr_q + 32'd4;
            end
        end
    end

    // Datapath registers; reset also discards any read beat still in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

endmodule
